// File: rtl/noc_input_buffer.sv
// Per-port input stage of the 5-port router: small flit FIFO plus XY route lock.
// The head flit picks the output port once; the route is held until the packet's tail leaves.
module noc_input_buffer #(
    parameter int X_ADDR = 1,
    parameter int Y_ADDR = 1,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_flit,
    input  logic              in_valid,
    output logic              full,
    output logic [7:0]        out_flit,
    output logic [2:0]        request,
    input  logic              grant,
    output logic              drop,
    output logic [ADDR_W:0]   occupancy
);

    localparam logic [2:0] REQ_L    = 3'd0;
    localparam logic [2:0] REQ_N    = 3'd1;
    localparam logic [2:0] REQ_E    = 3'd2;
    localparam logic [2:0] REQ_S    = 3'd3;
    localparam logic [2:0] REQ_W    = 3'd4;
    localparam logic [2:0] REQ_IDLE = 3'd7;

    localparam logic [2:0]      MY_X    = 3'(X_ADDR);
    localparam logic [2:0]      MY_Y    = 3'(Y_ADDR);
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          route_reg, route_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]     count_reg, count_next;
    logic [7:0]          mem_reg [DEPTH];

    logic                empty;
    logic                push;
    logic                pop;
    logic [7:0]          head_flit;
    logic [2:0]          head_route;
    logic                head_starts_packet;
    logic                head_ends_packet;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == COUNT_FULL);
    assign occupancy = count_reg;
    assign head_flit = mem_reg[rd_ptr_reg];
    assign out_flit  = empty ? 8'h00 : head_flit;

    // Types 01 (head) and 11 (single) open a packet; 10 (tail) and 11 (single) close one.
    assign head_starts_packet = head_flit[6];
    assign head_ends_packet   = head_flit[7];

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for this push.
    assign push = in_valid && !full;

    // Dimension-ordered route: resolve X first, then Y, else eject locally.
    always_comb begin
        head_route = REQ_L;
        if (head_flit[5:3] > MY_X) begin
            head_route = REQ_E;
        end else if (head_flit[5:3] < MY_X) begin
            head_route = REQ_W;
        end else if (head_flit[2:0] > MY_Y) begin
            head_route = REQ_N;
        end else if (head_flit[2:0] < MY_Y) begin
            head_route = REQ_S;
        end
    end

    always_comb begin
        state_next = state_reg;
        route_next = route_reg;
        request    = REQ_IDLE;
        drop       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    if (head_starts_packet) begin
                        route_next = head_route;
                        state_next = ACTIVE;
                    end else begin
                        // Body/tail with no open packet: discard one per cycle.
                        drop = 1'b1;
                        pop  = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (!empty) begin
                    request = route_reg;
                    if (grant) begin
                        pop = 1'b1;
                        if (head_ends_packet) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            route_reg  <= REQ_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            route_reg  <= route_next;
            count_reg  <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == ADDR_W'(gi))) begin
                    mem_reg[gi] <= in_flit;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer: a packet-level queue model checked every cycle,
// plus hand-computed expectations for routing, locking, backpressure, drops and wrap.
module tb_noc_input_buffer;

    localparam int X     = 1;
    localparam int Y     = 1;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst;
    logic [7:0]    in_flit;
    logic          in_valid;
    logic          full;
    logic [7:0]    out_flit;
    logic [2:0]    request;
    logic          grant;
    logic          drop;
    logic [AW:0]   occupancy;

    int n_checks = 0;
    int n_errors = 0;

    noc_input_buffer #(
        .X_ADDR(X),
        .Y_ADDR(Y),
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_valid (in_valid),
        .full     (full),
        .out_flit (out_flit),
        .request  (request),
        .grant    (grant),
        .drop     (drop),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    logic [2:0] m_route  = 3'd7;
    int         m_sz;
    logic [7:0] m_f;
    bit         m_push;

    function automatic logic [2:0] xy(input logic [7:0] f);
        logic [2:0] dx, dy;
        dx = f[5:3];
        dy = f[2:0];
        if (dx > 3'(X)) return 3'd2;
        if (dx < 3'(X)) return 3'd4;
        if (dy > 3'(Y)) return 3'd1;
        if (dy < 3'(Y)) return 3'd3;
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_route  = 3'd7;
        end else begin
            m_sz   = m_q.size();
            m_push = in_valid && (m_sz < DEPTH);
            if (m_active && m_sz > 0 && grant) begin
                m_f = m_q.pop_front();
                if (m_f[7]) m_active = 1'b0;
            end else if (!m_active && m_sz > 0) begin
                if (m_q[0][6]) begin
                    m_active = 1'b1;
                    m_route  = xy(m_q[0]);
                end else begin
                    m_f = m_q.pop_front();
                end
            end
            if (m_push) m_q.push_back(in_flit);
        end
    end

    always @(negedge clk) begin
        chk("full",      int'(full),      int'(m_q.size() == DEPTH));
        chk("occupancy", int'(occupancy), m_q.size());
        chk("out_flit",  int'(out_flit),  (m_q.size() > 0) ? int'(m_q[0]) : 0);
        chk("request",   int'(request),   (m_active && m_q.size() > 0) ? int'(m_route) : 7);
        chk("drop",      int'(drop),      int'(!m_active && m_q.size() > 0 && !m_q[0][6]));
    end

    // ---------------- stimulus ----------------
    bit         rec = 1'b0;
    logic [7:0] rx[$];
    int         bubbles = 0;
    int         bad_route = 0;

    task automatic drive(input logic v, input logic [7:0] f, input logic g);
        in_valid = v;
        in_flit  = f;
        grant    = g;
        #1;
        if (rec) begin
            if (request != 3'd7 && grant) rx.push_back(out_flit);
            if (request == 3'd7 && rx.size() > 0 && rx.size() < 10) bubbles++;
            if (request != 3'd7 && request != 3'd2) bad_route++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] rt_flit [5] = '{8'hC9, 8'hD1, 8'hC1, 8'hCA, 8'hC8};
    logic [2:0] rt_req  [5] = '{3'd0, 3'd2, 3'd4, 3'd1, 3'd3};
    logic [7:0] pkt     [10] = '{8'h51, 8'h01, 8'h02, 8'h03, 8'h04,
                                 8'h05, 8'h06, 8'h07, 8'h08, 8'h89};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_flit  = 8'h00;
        grant    = 1'b0;
        #1 rst = 1'b0;
        #11;
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_req", int'(request), 7);
        chk("rst_full", int'(full), 0);
        #5 rst = 1'b1;
        tick();

        // Routing of single flits from router (1,1)
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rt_flit[i], 1'b1);
            tick();
            chk("route_pre", int'(request), 7);
            drive(1'b0, 8'h00, 1'b1);
            tick();
            chk("route_req", int'(request), int'(rt_req[i]));
            tick();
            chk("route_occ", int'(occupancy), 0);
            chk("route_idle", int'(request), 7);
            $display("route flit=0x%02h request=%0d", rt_flit[i], rt_req[i]);
        end

        // Packet lock
        drive(1'b1, 8'h51, 1'b0); tick();
        drive(1'b1, 8'h15, 1'b0); tick();
        drive(1'b1, 8'h80, 1'b0); tick();
        chk("lock_req", int'(request), 2);
        chk("lock_occ", int'(occupancy), 3);
        drive(1'b0, 8'h00, 1'b1);
        chk("lock_f0", int'(out_flit), 8'h51);
        tick();
        chk("lock_f1", int'(out_flit), 8'h15);
        chk("lock_req1", int'(request), 2);
        tick();
        chk("lock_f2", int'(out_flit), 8'h80);
        tick();
        chk("lock_end", int'(request), 7);
        chk("lock_occ0", int'(occupancy), 0);
        $display("packet lock 51/15/80 drained");

        // Full and backpressure
        drive(1'b1, 8'h51, 1'b0); tick();
        drive(1'b1, 8'h01, 1'b0); tick();
        drive(1'b1, 8'h02, 1'b0); tick();
        drive(1'b1, 8'h83, 1'b0); tick();
        chk("bp_full", int'(full), 1);
        chk("bp_occ4", int'(occupancy), 4);
        drive(1'b1, 8'h04, 1'b0); tick();
        chk("bp_ignored", int'(occupancy), 4);
        drive(1'b1, 8'h05, 1'b1); tick();
        chk("bp_blocked", int'(occupancy), 3);
        chk("bp_head", int'(out_flit), 8'h01);
        drive(1'b1, 8'hC9, 1'b0); tick();
        chk("bp_accept", int'(occupancy), 4);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        chk("bp_drained", int'(occupancy), 0);
        $display("backpressure full/blocked/accepted");

        // Orphan drop
        drive(1'b1, 8'h15, 1'b0); tick();
        chk("drop_1", int'(drop), 1);
        chk("drop_req", int'(request), 7);
        drive(1'b1, 8'h80, 1'b0); tick();
        chk("drop_2", int'(drop), 1);
        chk("drop_occ1", int'(occupancy), 1);
        drive(1'b0, 8'h00, 1'b0); tick();
        chk("drop_3", int'(drop), 0);
        chk("drop_occ0", int'(occupancy), 0);
        $display("orphan drop 15/80");

        // Wrap and bubble
        rec = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, pkt[i], 1'b1); tick();
            drive(1'b0, 8'h00, 1'b1); tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1); tick();
        end
        rec = 1'b0;
        chk("wrap_count", rx.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_order", (i < rx.size()) ? int'(rx[i]) : -1, int'(pkt[i]));
        end
        chk("wrap_bubble", int'(bubbles > 0), 1);
        chk("wrap_route", bad_route, 0);
        $display("wrap stream 10 flits, bubbles=%0d", bubbles);

        // Reset mid-traffic
        drive(1'b1, 8'h51, 1'b0); tick();
        drive(1'b1, 8'h01, 1'b0); tick();
        chk("mr_occ2", int'(occupancy), 2);
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        #25;
        rst = 1'b1;
        chk("mr_occ", int'(occupancy), 0);
        chk("mr_full", int'(full), 0);
        chk("mr_req", int'(request), 7);
        chk("mr_drop", int'(drop), 0);
        chk("mr_out", int'(out_flit), 0);
        tick();
        chk("mr_after", int'(occupancy), 0);
        chk("mr_after_req", int'(request), 7);
        $display("reset mid-traffic cleared buffer");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
